rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single write port of the 32×32 register file between two requesters: requester 0 is the multi-cycle CPU writeback path, requester 1 is the debug/initialisation unit. Grants use round-robin on a valid/ready handshake, with an optional lock that gives requester 1 exclusive burst access. The granted write is registered onto the register file's `we/wa/wd` inputs. The block sits between the CPU/debug logic and the register file.

## Interface
- `M`, 5, register address width (register count = 1<<M)
- `N`, 32, data width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low (0 = reset)
- `valid0`  in  1  requester 0 write request
- `addr0`  in  M  requester 0 destination register
- `data0`  in  N  requester 0 write data
- `ready0`  out  1  requester 0 granted this cycle
- `valid1`  in  1  requester 1 write request
- `lock1`  in  1  requester 1 requests/holds exclusive access
- `addr1`  in  M  requester 1 destination register
- `data1`  in  N  requester 1 write data
- `ready1`  out  1  requester 1 granted this cycle
- `rf_we`  out  1  register file write enable
- `rf_wa`  out  M  register file write address
- `rf_wd`  out  N  register file write data
- `locked`  out  1  high while in LOCK state

## Operation
- Transfer occurs on requester k when `valid_k && ready_k` at a rising edge. A requester holds valid, addr and data stable until it sees ready.
- `ready0/ready1` are combinational from the valids, the FSM state and the priority pointer. At most one is high in a cycle. Ready is never high without the matching valid.
- Priority pointer `last` (1 bit) holds the index of the most recent grant. With both valid in state ARB, the grant goes to `!last`. With one valid, that one is granted. `last` updates on every transfer.
- FSM states:
  - ARB: round-robin as above.
  - LOCK: only requester 1 is grantable, and `ready0`=0.
- ARB→LOCK: requester 1 transfer with `lock1`=1.
- LOCK→ARB: any cycle with `lock1`=0 in LOCK. A transfer in that same cycle still completes, and the new state applies from the next cycle.
- `locked` = (state==LOCK), registered.
- Output stage:
  - On a transfer, `rf_we`←1, `rf_wa`←addr, `rf_wd`←data.
  - With no transfer, `rf_we`←0, and `rf_wa/rf_wd` hold their previous values.
- No backpressure from the register file, so one write per cycle is sustained. Back-to-back alternating grants are allowed.
- Reset (rst=0 at edge): state=ARB, `last`=1 (requester 0 wins the first tie), `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `locked`=0.
  - `ready0/ready1` are forced to 0 during the reset cycle.
  - Reset during LOCK abandons the lock. No pending write survives reset.

## Timing
- Handshake to `rf_we` high: 1 cycle (registered). Register file content updates at the edge after that: 2 edges from the handshake edge.
- Requester-visible throughput: 1 write/cycle.
- Fairness under contention (both valid, no lock): grants alternate 0,1,0,1,… starting with requester 0 after reset.
- Lock latency: the grant following a locking transfer is already exclusive (requester 0 blocked from the next cycle).

## Configuration
- Macro: `RF_ARB_ZERO_GUARD_EN`.
- Defined: a transfer with addr==0 still completes the handshake and updates `last`/FSM, but `rf_we` stays 0 that cycle and `rf_wa/rf_wd` hold. This keeps `$0` constant.
- Undefined: addr==0 is forwarded like any other address.

## Structure
- Package `rf_arb_pkg`: FSM state encoding (ARB, LOCK), requester index constants `REQ_CPU`=0 and `REQ_DBG`=1, and default `M`/`N` localparams.
- Sub-module `rr_pick2` computes the grant from valid0, valid1, last, and a mask0 input that blocks requester 0 in LOCK.
- The top level holds the FSM, the `last` register and the output registers.

## Test plan
- Reset, then valid0 with addr0=3, data0=0xDEADBEEF: `ready0`=1 the same cycle; next cycle `rf_we`=1, `rf_wa`=3, `rf_wd`=0xDEADBEEF; following cycle `rf_we`=0 and wa/wd held.
- Both valid continuously for 4 cycles after reset: grant sequence 0,1,0,1; `rf_wa` follows the corresponding addresses; never both ready.
- Requester 1 transfers with lock1=1, then valid0 and valid1 both held: only `ready1` for 3 cycles and `locked`=1. Drop lock1: `locked`=0 next cycle and requester 0 is granted.
- Reset asserted while in LOCK with valid1 high: next cycle state=ARB, `locked`=0, `rf_we`=0, ready outputs 0 during reset.
- valid0 with addr0=0, data0=0x1234: macro defined → handshake completes and `rf_we` stays 0; macro undefined → `rf_we`=1, `rf_wa`=0.
- Random valids/locks over 10k cycles with a scoreboard: every transfer appears exactly once on rf_* one cycle later, in grant order, and requester 0 is never granted in LOCK.

Source files
------------

// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared types and constants for the register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int DEF_M = 5;
  localparam int DEF_N = 32;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin grant; mask0 removes requester 0 from contention.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  input  logic mask0,
  output logic gnt0,
  output logic gnt1
);

  logic w_cand0;

  assign w_cand0 = valid0 & ~mask0;
  // On a tie the requester that did not win last time goes next.
  assign gnt0    = w_cand0 & (~valid1 | last);
  assign gnt1    = valid1 & (~w_cand0 | ~last);

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin/lockable arbiter for the register file write port.
//               Define RF_ARB_ZERO_GUARD_EN to suppress writes to register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid0,
  input  logic [M-1:0] addr0,
  input  logic [N-1:0] data0,
  output logic         ready0,
  input  logic         valid1,
  input  logic         lock1,
  input  logic [M-1:0] addr1,
  input  logic [N-1:0] data1,
  output logic         ready1,
  output logic         rf_we,
  output logic [M-1:0] rf_wa,
  output logic [N-1:0] rf_wd,
  output logic         locked
);

  arb_state_t   r_state;
  arb_state_t   w_state_nxt;
  logic         r_last;
  logic         w_mask0;
  logic         w_gnt0;
  logic         w_gnt1;
  logic         w_xfer;
  logic         w_wr;
  logic [M-1:0] w_addr;
  logic [N-1:0] w_data;
  logic         r_we;
  logic [M-1:0] r_wa;
  logic [N-1:0] r_wd;

  assign w_mask0 = (r_state == LOCK);

  rr_pick2 u_pick (
    .valid0 (valid0),
    .valid1 (valid1),
    .last   (r_last),
    .mask0  (w_mask0),
    .gnt0   (w_gnt0),
    .gnt1   (w_gnt1)
  );

  // No grant may be issued while reset is being applied.
  assign ready0 = rst & w_gnt0;
  assign ready1 = rst & w_gnt1;
  assign w_xfer = ready0 | ready1;
  assign w_addr = ready1 ? addr1 : addr0;
  assign w_data = ready1 ? data1 : data0;

`ifdef RF_ARB_ZERO_GUARD_EN
  assign w_wr = w_xfer & (w_addr != '0);
`else
  assign w_wr = w_xfer;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (ready1 && lock1) w_state_nxt = LOCK;
      LOCK:    if (!lock1)          w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= REQ_DBG;
    end else if (ready0) begin
      r_last <= REQ_CPU;
    end else if (ready1) begin
      r_last <= REQ_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_wa <= w_addr;
        r_wd <= w_data;
      end
    end
  end

  assign rf_we  = r_we;
  assign rf_wa  = r_wa;
  assign rf_wd  = r_wd;
  assign locked = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic        ready0;
  logic        valid1;
  logic        lock1;
  logic [4:0]  addr1;
  logic [31:0] data1;
  logic        ready1;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        locked;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter #(.M(5), .N(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .valid0 (valid0),
    .addr0  (addr0),
    .data0  (data0),
    .ready0 (ready0),
    .valid1 (valid1),
    .lock1  (lock1),
    .addr1  (addr1),
    .data1  (data1),
    .ready1 (ready1),
    .rf_we  (rf_we),
    .rf_wa  (rf_wa),
    .rf_wd  (rf_wd),
    .locked (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  initial begin
    logic [31:0] wd_before;

    rst = 1'b0; valid0 = 1'b1; addr0 = 5'd1; data0 = 32'h1;
    valid1 = 1'b1; lock1 = 1'b0; addr1 = 5'd2; data1 = 32'h2;
    tick();
    tick();
    #1;
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_ready1", {31'd0, ready1}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_wa", {27'd0, rf_wa}, 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);

    // Single write from requester 0
    valid1 = 1'b0;
    rst = 1'b1; valid0 = 1'b1; addr0 = 5'd3; data0 = 32'hDEADBEEF;
    #1;
    chk("single_ready0", {31'd0, ready0}, 32'd1);
    chk("single_ready1", {31'd0, ready1}, 32'd0);
    tick();
    valid0 = 1'b0;
    chk("single_we", {31'd0, rf_we}, 32'd1);
    chk("single_wa", {27'd0, rf_wa}, 32'd3);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    tick();
    chk("idle_we", {31'd0, rf_we}, 32'd0);
    chk("idle_wa", {27'd0, rf_wa}, 32'd3);
    chk("idle_wd", rf_wd, 32'hDEADBEEF);

    // Contention after a fresh reset: 0,1,0,1
    rst = 1'b0;
    tick();
    rst = 1'b1;
    valid0 = 1'b1; addr0 = 5'd5; data0 = 32'hA0;
    valid1 = 1'b1; addr1 = 5'd9; data1 = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready0_%0d", i), {31'd0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_ready1_%0d", i), {31'd0, ready1}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk($sformatf("rr_we_%0d", i), {31'd0, rf_we}, 32'd1);
      chk($sformatf("rr_wa_%0d", i), {27'd0, rf_wa}, (i % 2 == 0) ? 32'd5 : 32'd9);
      chk($sformatf("rr_wd_%0d", i), rf_wd, (i % 2 == 0) ? 32'hA0 : 32'hB1);
    end

    // Locking transfer from requester 1
    valid0 = 1'b0; lock1 = 1'b1; addr1 = 5'd7; data1 = 32'hC7;
    #1;
    chk("lock_req_ready1", {31'd0, ready1}, 32'd1);
    tick();
    chk("lock_locked", {31'd0, locked}, 32'd1);
    chk("lock_wa", {27'd0, rf_wa}, 32'd7);
    valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("lock_ready0_%0d", i), {31'd0, ready0}, 32'd0);
      chk($sformatf("lock_ready1_%0d", i), {31'd0, ready1}, 32'd1);
      chk($sformatf("lock_held_%0d", i), {31'd0, locked}, 32'd1);
      tick();
    end
    // Dropping lock1: this cycle's transfer still goes to requester 1
    lock1 = 1'b0; addr1 = 5'd8; data1 = 32'hC8;
    #1;
    chk("unlock_ready1", {31'd0, ready1}, 32'd1);
    chk("unlock_ready0", {31'd0, ready0}, 32'd0);
    tick();
    chk("unlock_locked", {31'd0, locked}, 32'd0);
    chk("unlock_wa", {27'd0, rf_wa}, 32'd8);
    chk("unlock_ready0_next", {31'd0, ready0}, 32'd1);
    chk("unlock_ready1_next", {31'd0, ready1}, 32'd0);

    // Reset while locked
    valid0 = 1'b0; valid1 = 1'b1; lock1 = 1'b1;
    tick();
    chk("relock_locked", {31'd0, locked}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstlock_ready0", {31'd0, ready0}, 32'd0);
    chk("rstlock_ready1", {31'd0, ready1}, 32'd0);
    tick();
    chk("rstlock_locked", {31'd0, locked}, 32'd0);
    chk("rstlock_we", {31'd0, rf_we}, 32'd0);
    rst = 1'b1; lock1 = 1'b0; valid0 = 1'b1; addr0 = 5'd4; data0 = 32'h44;
    #1;
    chk("postrst_ready0", {31'd0, ready0}, 32'd1);
    chk("postrst_ready1", {31'd0, ready1}, 32'd0);
    tick();
    valid1 = 1'b0;
    chk("postrst_wa", {27'd0, rf_wa}, 32'd4);
    wd_before = rf_wd;

    // Write to register 0
    addr0 = 5'd0; data0 = 32'h1234;
    #1;
    chk("zero_ready0", {31'd0, ready0}, 32'd1);
    tick();
    valid0 = 1'b0;
`ifdef RF_ARB_ZERO_GUARD_EN
    chk("zero_we", {31'd0, rf_we}, 32'd0);
    chk("zero_wa", {27'd0, rf_wa}, 32'd4);
    chk("zero_wd", rf_wd, wd_before);
`else
    chk("zero_we", {31'd0, rf_we}, 32'd1);
    chk("zero_wa", {27'd0, rf_wa}, 32'd0);
    chk("zero_wd", rf_wd, 32'h1234);
`endif
    tick();
    chk("final_we", {31'd0, rf_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
